// File: rtl/ntt_agu.sv
// Address and twiddle-index sequencer for a single-cycle NTT/INTT butterfly.
// Issues one coefficient pair plus twiddle ROM index per handshake, CT or GS order.
module ntt_agu #(
    parameter int LOG_N = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sel_butterfly_i,
    input  logic             sel_red_i,
    input  logic             stall_i,
    output logic             valid_o,
    output logic [LOG_N-1:0] addr_a_o,
    output logic [LOG_N-1:0] addr_b_o,
    output logic [LOG_N-1:0] twiddle_idx_o,
    output logic             sel_butterfly_o,
    output logic             sel_red_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int LW = $clog2(LOG_N);
    localparam int PW = LOG_N - 1;
    localparam int XW = LOG_N + 1;

    localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);
    localparam logic [LOG_N-1:0] HALF = ONE << (LOG_N - 1);
    localparam logic [XW-1:0]    FULL = XW'(1) << LOG_N;
    localparam logic [PW-1:0]    PMAX = {PW{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [LW-1:0]    ll_q, ll_d;
    logic             bfly_q, bfly_d;
    logic             red_q, red_d;
    logic             valid_q, valid_d;
    logic [LOG_N-1:0] a_q, a_d;
    logic [LOG_N-1:0] b_q, b_d;
    logic [LOG_N-1:0] tw_q, tw_d;

    logic             load;
    logic             hs;
    logic [LW-1:0]    last_ll;
    logic [LOG_N-1:0] len, g, o, beat_a, beat_b, beat_tw;

    // ll holds log2(len); the layer index walks down for CT and up for GS
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        ll_d    = ll_q;
        bfly_d  = bfly_q;
        red_d   = red_q;
        valid_d = valid_q;
        load    = 1'b0;
        hs      = valid_q && !stall_i;
        last_ll = bfly_q ? LW'(LOG_N - 1) : LW'(red_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    bfly_d  = sel_butterfly_i;
                    red_d   = sel_red_i;
                    p_d     = '0;
                    ll_d    = sel_butterfly_i ? LW'(sel_red_i) : LW'(LOG_N - 1);
                    valid_d = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (hs) begin
                    if (p_q == PMAX && ll_q == last_ll) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else begin
                        p_d  = p_q + PW'(1);
                        load = 1'b1;
                        if (p_q == PMAX) begin
                            ll_d = bfly_q ? ll_q + LW'(1) : ll_q - LW'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat arithmetic on the counters the next beat will use
    always_comb begin
        len     = ONE << ll_d;
        g       = LOG_N'(p_d) >> ll_d;
        o       = LOG_N'(p_d) & (len - ONE);
        beat_a  = ((g << ll_d) << 1) | o;
        beat_b  = beat_a + len;
        if (bfly_d) begin
            beat_tw = LOG_N'((FULL >> ll_d) - XW'(1) - XW'(g));
        end else begin
            beat_tw = (HALF >> ll_d) + g;
        end
    end

    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        tw_d = tw_q;
        if (load) begin
            a_d  = beat_a;
            b_d  = beat_b;
            tw_d = beat_tw;
        end else if (!valid_d) begin
            a_d  = '0;
            b_d  = '0;
            tw_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            p_q     <= '0;
            ll_q    <= '0;
            bfly_q  <= 1'b0;
            red_q   <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            ll_q    <= ll_d;
            bfly_q  <= bfly_d;
            red_q   <= red_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tw_q    <= tw_d;
        end
    end

    assign valid_o         = valid_q;
    assign addr_a_o        = a_q;
    assign addr_b_o        = b_q;
    assign twiddle_idx_o   = tw_q;
    assign sel_butterfly_o = bfly_q;
    assign sel_red_o       = red_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_ntt_agu.sv
// Directed bench for ntt_agu: full CT/GS runs for both schemes, stall, reset and ignored starts.
module tb_ntt_agu;

    localparam int LOG_N = 8;
    localparam int N     = 256;
    localparam int H     = 128;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic             sel_butterfly_i;
    logic             sel_red_i;
    logic             stall_i;
    logic             valid_o;
    logic [LOG_N-1:0] addr_a_o;
    logic [LOG_N-1:0] addr_b_o;
    logic [LOG_N-1:0] twiddle_idx_o;
    logic             sel_butterfly_o;
    logic             sel_red_o;
    logic             busy_o;
    logic             done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [23:0] exp_q[$];
    logic [23:0] cap[0:1023];

    always #5 clk = ~clk;

    ntt_agu #(.LOG_N(LOG_N)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .sel_butterfly_i (sel_butterfly_i),
        .sel_red_i       (sel_red_i),
        .stall_i         (stall_i),
        .valid_o         (valid_o),
        .addr_a_o        (addr_a_o),
        .addr_b_o        (addr_b_o),
        .twiddle_idx_o   (twiddle_idx_o),
        .sel_butterfly_o (sel_butterfly_o),
        .sel_red_o       (sel_red_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Textbook loop nest: running twiddle counter k, one value per butterfly group
    task automatic build(input bit bfly, input bit red);
        int k;
        int lo_len;
        exp_q.delete();
        lo_len = red ? 2 : 1;
        if (!bfly) begin
            k = 1;
            for (int len = H; len >= lo_len; len = len / 2) begin
                for (int s = 0; s < N; s += 2 * len) begin
                    for (int j = s; j < s + len; j++)
                        exp_q.push_back({8'(j), 8'(j + len), 8'(k)});
                    k++;
                end
            end
        end else begin
            k = red ? H : N;
            for (int len = lo_len; len <= H; len = len * 2) begin
                for (int s = 0; s < N; s += 2 * len) begin
                    k--;
                    for (int j = s; j < s + len; j++)
                        exp_q.push_back({8'(j), 8'(j + len), 8'(k)});
                end
            end
        end
    endtask

    task automatic run(input bit bfly, input bit red, input int stall_at, input int stall_len,
                       input int abort_at, input bit poke_start);
        int idx;
        int stalled;
        int n;
        idx     = 0;
        stalled = 0;
        build(bfly, red);
        n = exp_q.size();
        cyc             = 0;
        sel_butterfly_i = bfly;
        sel_red_i       = red;
        start_i         = 1'b1;
        step();
        start_i         = 1'b0;
        sel_butterfly_i = ~bfly;
        sel_red_i       = ~red;
        while (cyc < 3000) begin
            if (done_o === 1'b1) break;
            check("valid_run", {31'b0, valid_o}, 32'd1);
            if (idx < n)
                check($sformatf("beat%0d", idx),
                      {6'b0, sel_butterfly_o, sel_red_o, addr_a_o, addr_b_o, twiddle_idx_o},
                      {6'b0, bfly, red, exp_q[idx]});
            if (idx == abort_at) begin
                rst_ni = 1'b0;
                #1;
                check("rst_outputs",
                      {valid_o, busy_o, done_o, sel_butterfly_o, sel_red_o, addr_a_o, addr_b_o, twiddle_idx_o},
                      32'd0);
                start_i = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    step();
                    check("rst_hold", {valid_o, busy_o, done_o}, 32'd0);
                end
                start_i = 1'b0;
                rst_ni  = 1'b1;
                step();
                check("post_rst_idle", {valid_o, busy_o, done_o}, 32'd0);
                return;
            end
            stall_i = 1'b0;
            if (idx == stall_at && stalled < stall_len) begin
                stall_i = 1'b1;
                stalled++;
            end else begin
                if (idx < 1024) cap[idx] = {addr_a_o, addr_b_o, twiddle_idx_o};
                idx++;
            end
            start_i = (poke_start && (cyc == 50 || cyc == 700)) ? 1'b1 : 1'b0;
            step();
        end
        stall_i = 1'b0;
        start_i = 1'b0;
        check("done_cycle", cyc, 1 + n + stall_len);
        check("beat_count", idx, n);
        check("done_state", {valid_o, busy_o, done_o, addr_a_o, addr_b_o, twiddle_idx_o}, {3'b011, 24'd0});
        if (poke_start) start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("after_done", {valid_o, busy_o, done_o}, 32'd0);
        check("sel_hold", {sel_butterfly_o, sel_red_o}, {bfly, red});
        step();
        check("idle_stays", {valid_o, busy_o, done_o}, 32'd0);
    endtask

    initial begin
        rst_ni          = 1'b0;
        start_i         = 1'b0;
        sel_butterfly_i = 1'b0;
        sel_red_i       = 1'b0;
        stall_i         = 1'b0;
        #2;
        check("reset_state",
              {valid_o, busy_o, done_o, sel_butterfly_o, sel_red_o, addr_a_o, addr_b_o, twiddle_idx_o},
              32'd0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        run(1'b0, 1'b0, -1, 0, -1, 1'b0);
        check("ctd_b0",    cap[0],    {8'd0,   8'd128, 8'd1});
        check("ctd_b128",  cap[128],  {8'd0,   8'd64,  8'd2});
        check("ctd_b192",  cap[192],  {8'd128, 8'd192, 8'd3});
        check("ctd_b1023", cap[1023], {8'd254, 8'd255, 8'd255});

        run(1'b0, 1'b1, -1, 0, -1, 1'b0);
        check("ctk_b0",   cap[0],   {8'd0,   8'd128, 8'd1});
        check("ctk_last", cap[895], {8'd253, 8'd255, 8'd127});

        run(1'b1, 1'b0, -1, 0, -1, 1'b0);
        check("gsd_b0",   cap[0],    {8'd0,   8'd1,   8'd255});
        check("gsd_last", cap[1023], {8'd127, 8'd255, 8'd1});

        run(1'b1, 1'b1, -1, 0, -1, 1'b0);
        check("gsk_b0",   cap[0],   {8'd0,   8'd2,   8'd127});
        check("gsk_last", cap[895], {8'd127, 8'd255, 8'd1});

        run(1'b0, 1'b0, 10, 5, -1, 1'b0);
        check("stall_b10", cap[10], {8'd10, 8'd138, 8'd1});
        check("stall_b11", cap[11], {8'd11, 8'd139, 8'd1});

        run(1'b0, 1'b0, -1, 0, 300, 1'b0);
        run(1'b0, 1'b0, -1, 0, -1, 1'b1);
        check("restart_b0",   cap[0],    {8'd0,   8'd128, 8'd1});
        check("restart_last", cap[1023], {8'd254, 8'd255, 8'd255});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
